// File: rtl/hdmi_video_timing_pkg.sv
// Shared raster/format definitions for the ADV7513 video path: timing presets,
// FSM encoding and the transmitter input format agreed with the I2C init block.
package hdmi_video_timing_pkg;

  localparam int unsigned STATE_W = 1;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // ADV7513 input ID 0: 24-bit RGB 4:4:4 with separate HS/VS/DE
  localparam int unsigned ADV7513_RGB_W    = 24;
  localparam logic [3:0]  ADV7513_INPUT_ID = 4'h0;

  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_active;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
    logic        hs_pol;
    logic        vs_pol;
  } timing_preset_t;

  localparam timing_preset_t PRESET_640X480_60 = '{
    h_active: 16'd640,  h_fp: 16'd16, h_sync: 16'd96, h_bp: 16'd48,
    v_active: 16'd480,  v_fp: 16'd10, v_sync: 16'd2,  v_bp: 16'd33,
    hs_pol:   1'b0,     vs_pol: 1'b0
  };

  localparam timing_preset_t PRESET_1280X720_60 = '{
    h_active: 16'd1280, h_fp: 16'd110, h_sync: 16'd40, h_bp: 16'd220,
    v_active: 16'd720,  v_fp: 16'd5,   v_sync: 16'd5,  v_bp: 16'd20,
    hs_pol:   1'b1,     vs_pol: 1'b1
  };

  localparam timing_preset_t PRESET_1920X1080_60 = '{
    h_active: 16'd1920, h_fp: 16'd88, h_sync: 16'd44, h_bp: 16'd148,
    v_active: 16'd1080, v_fp: 16'd4,  v_sync: 16'd5,  v_bp: 16'd36,
    hs_pol:   1'b1,     vs_pol: 1'b1
  };

  function automatic int unsigned axis_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/hdmi_video_timing_if.sv
// Pixel-request / video-pin bundle between the frame source, the timing
// generator and the ADV7513 parallel input.
interface hdmi_video_timing_if
  import hdmi_video_timing_pkg::*;
#(
  parameter int unsigned CW = 12
);
  logic                     enable;
  logic [ADV7513_RGB_W-1:0] rgb_in;
  logic                     pix_req;
  logic [CW-1:0]            pix_x;
  logic [CW-1:0]            pix_y;
  logic [ADV7513_RGB_W-1:0] hdmi_d;
  logic                     hdmi_de;
  logic                     hdmi_hs;
  logic                     hdmi_vs;
  logic                     frame_start;
  logic                     running;

  modport master (
    input  enable, rgb_in,
    output pix_req, pix_x, pix_y, hdmi_d, hdmi_de, hdmi_hs, hdmi_vs,
           frame_start, running
  );

  modport slave (
    output enable, rgb_in,
    input  pix_req, pix_x, pix_y, hdmi_d, hdmi_de, hdmi_hs, hdmi_vs,
           frame_start, running
  );
endinterface

// File: rtl/hdmi_video_timing_sync_axis_counter.sv
// One raster axis: wrapping position counter with active and sync window decode.
// Layout along the axis is active, front porch, sync, back porch.
module sync_axis_counter
  import hdmi_video_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  parameter int unsigned CW     = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          end_o,
  output logic          active_o,
  output logic          sync_o
);

  localparam int unsigned TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
  localparam int unsigned SYNC_START = ACTIVE + FP;
  localparam int unsigned SYNC_END   = SYNC_START + SYNC;

  logic [CW-1:0] cnt_q, cnt_d;

  assign end_o    = (cnt_q == CW'(TOTAL - 1));
  assign active_o = (cnt_q < CW'(ACTIVE));
  assign sync_o   = (cnt_q >= CW'(SYNC_START)) && (cnt_q < CW'(SYNC_END));
  assign cnt_o    = cnt_q;

  // wrap by explicit compare so non-power-of-two totals work
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = CW'(0);
    end else if (inc_i) begin
      cnt_d = end_o ? CW'(0) : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= CW'(0);
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hdmi_video_timing.sv
// Raster timing generator and registered pixel stage for the ADV7513 input.
// Requests pixels by X/Y one cycle ahead of driving them onto the pins.
module hdmi_video_timing
  import hdmi_video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 32'(PRESET_640X480_60.h_active),
  parameter int unsigned H_FP     = 32'(PRESET_640X480_60.h_fp),
  parameter int unsigned H_SYNC   = 32'(PRESET_640X480_60.h_sync),
  parameter int unsigned H_BP     = 32'(PRESET_640X480_60.h_bp),
  parameter int unsigned V_ACTIVE = 32'(PRESET_640X480_60.v_active),
  parameter int unsigned V_FP     = 32'(PRESET_640X480_60.v_fp),
  parameter int unsigned V_SYNC   = 32'(PRESET_640X480_60.v_sync),
  parameter int unsigned V_BP     = 32'(PRESET_640X480_60.v_bp),
  parameter bit          HS_POL   = PRESET_640X480_60.hs_pol,
  parameter bit          VS_POL   = PRESET_640X480_60.vs_pol,
  parameter int unsigned CW       = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  hdmi_video_timing_if.master  vif
);

  state_e        state_q, state_d;
  logic          run;
  logic [CW-1:0] h_cnt, v_cnt;
  logic          h_end, h_act, h_sync;
  logic          v_end, v_act, v_sync;
  logic          pix_req_c;

  logic [ADV7513_RGB_W-1:0] d_q, d_d;
  logic de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;

  assign run = (state_q == ST_RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // enable is only honoured at a frame boundary once running
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (vif.enable) state_d = ST_RUN;
      ST_RUN:  if (h_end && v_end && !vif.enable) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  sync_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)
  ) u_h_axis (
    .clk     (clk),
    .rst     (reset),
    .clr_i   (!run),
    .inc_i   (run),
    .cnt_o   (h_cnt),
    .end_o   (h_end),
    .active_o(h_act),
    .sync_o  (h_sync)
  );

  // V advances on the H wrap, so VS edges land on h=0
  sync_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)
  ) u_v_axis (
    .clk     (clk),
    .rst     (reset),
    .clr_i   (!run),
    .inc_i   (run && h_end),
    .cnt_o   (v_cnt),
    .end_o   (v_end),
    .active_o(v_act),
    .sync_o  (v_sync)
  );

  assign pix_req_c   = run && h_act && v_act;
  assign vif.pix_req = pix_req_c;
  assign vif.pix_x   = h_cnt;
  assign vif.pix_y   = v_cnt;
  assign vif.running = run;

  always_comb begin
    de_d = pix_req_c;
    d_d  = pix_req_c ? vif.rgb_in : '0;
    hs_d = (run && h_sync) ? HS_POL : ~HS_POL;
    vs_d = (run && v_sync) ? VS_POL : ~VS_POL;
    fs_d = run && (h_cnt == CW'(0)) && (v_cnt == CW'(0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de_q <= 1'b0;
      d_q  <= '0;
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      fs_q <= 1'b0;
    end else begin
      de_q <= de_d;
      d_q  <= d_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      fs_q <= fs_d;
    end
  end

  assign vif.hdmi_de     = de_q;
  assign vif.hdmi_d      = d_q;
  assign vif.hdmi_hs     = hs_q;
  assign vif.hdmi_vs     = vs_q;
  assign vif.frame_start = fs_q;

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Scoreboard bench: a frame-position model predicts pins, a monitor compares.
module tb_hdmi_video_timing;

  localparam int unsigned HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int unsigned VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int unsigned CW = 12;
  localparam int HT    = int'(HA + HF + HS + HB);
  localparam int VT    = int'(VA + VF + VS + VB);
  localparam int FRAME = HT * VT;

  typedef struct {
    bit          de;
    logic [23:0] d0;
    logic [23:0] d1;
    bit          hsy;
    bit          vsy;
    bit          fs;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic enable;

  always #5 clk = ~clk;

  hdmi_video_timing_if #(.CW(CW)) vif0 ();
  hdmi_video_timing_if #(.CW(CW)) vif1 ();

  assign vif0.enable = enable;
  assign vif1.enable = enable;

  hdmi_video_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)
  ) dut0 (.clk(clk), .reset(reset), .vif(vif0));

  hdmi_video_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW)
  ) dut1 (.clk(clk), .reset(reset), .vif(vif1));

  int   errors = 0;
  int   checks = 0;
  bit   m_run  = 1'b0;
  int   m_p    = 0;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  // reference: position within the frame plus a running flag
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_run = 1'b0;
      m_p   = 0;
      exp_q.delete();
    end else begin
      exp_t e;
      int   h, v;
      h     = m_p % HT;
      v     = m_p / HT;
      e.de  = m_run && (h < int'(HA)) && (v < int'(VA));
      e.d0  = e.de ? vif0.rgb_in : 24'h0;
      e.d1  = e.de ? vif1.rgb_in : 24'h0;
      e.hsy = m_run && (h >= int'(HA + HF)) && (h < int'(HA + HF + HS));
      e.vsy = m_run && (v >= int'(VA + VF)) && (v < int'(VA + VF + VS));
      e.fs  = m_run && (m_p == 0);
      exp_q.push_back(e);
      if (!m_run) begin
        if (enable) begin
          m_run = 1'b1;
          m_p   = 0;
        end
      end else if (m_p == FRAME - 1) begin
        m_p = 0;
        if (!enable) m_run = 1'b0;
      end else begin
        m_p++;
      end
    end
  end

  // source pixels: dut0 gets a coordinate pattern, dut1 random data
  initial forever begin
    @(negedge clk);
    vif0.rgb_in = {8'(m_p / HT), 8'(m_p % HT), 8'hA5};
    vif1.rgb_in = 24'($urandom);
  end

  // registered pins
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (!reset && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("de0", 32'(vif0.hdmi_de), 32'(e.de));
      chk("d0",  32'(vif0.hdmi_d),  32'(e.d0));
      chk("hs0", 32'(vif0.hdmi_hs), 32'(!e.hsy));
      chk("vs0", 32'(vif0.hdmi_vs), 32'(!e.vsy));
      chk("fs0", 32'(vif0.frame_start), 32'(e.fs));
      chk("de1", 32'(vif1.hdmi_de), 32'(e.de));
      chk("d1",  32'(vif1.hdmi_d),  32'(e.d1));
      chk("hs1", 32'(vif1.hdmi_hs), 32'(e.hsy));
      chk("vs1", 32'(vif1.hdmi_vs), 32'(e.vsy));
      chk("fs1", 32'(vif1.frame_start), 32'(e.fs));
    end
  end

  // combinational request side
  initial forever begin
    bit req;
    @(negedge clk);
    #1;
    if (!reset) begin
      req = m_run && ((m_p % HT) < int'(HA)) && ((m_p / HT) < int'(VA));
      chk("pix_req0", 32'(vif0.pix_req), 32'(req));
      chk("pix_req1", 32'(vif1.pix_req), 32'(req));
      chk("running0", 32'(vif0.running), 32'(m_run));
      chk("running1", 32'(vif1.running), 32'(m_run));
      if (req) begin
        chk("pix_x", 32'(vif0.pix_x), 32'(m_p % HT));
        chk("pix_y", 32'(vif0.pix_y), 32'(m_p / HT));
      end
    end
  end

  task automatic wait_fs(input int budget, output int n, output bit ok);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vif0.frame_start && n < budget);
    ok = vif0.frame_start;
    if (!ok) timeout("frame_start");
  endtask

  task automatic wait_pos(input int target, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_run && m_p == target) && n < budget);
    if (!(m_run && m_p == target)) timeout("model_position");
  endtask

  initial begin
    int n, de_cnt;
    bit ok, fell;
    int rst_pos[2];
    rst_pos[0] = 2 * HT + 5;
    rst_pos[1] = HT + 1;

    reset = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_de",  32'(vif0.hdmi_de), 32'(0));
    chk("rst_d",   32'(vif0.hdmi_d), 32'(0));
    chk("rst_hs0", 32'(vif0.hdmi_hs), 32'(1));
    chk("rst_vs0", 32'(vif0.hdmi_vs), 32'(1));
    chk("rst_hs1", 32'(vif1.hdmi_hs), 32'(0));
    chk("rst_vs1", 32'(vif1.hdmi_vs), 32'(0));
    chk("rst_fs",  32'(vif0.frame_start), 32'(0));
    chk("rst_run", 32'(vif0.running), 32'(0));

    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b1;

    // frame 1, then frame 2 with enable dropped halfway through
    wait_fs(4 * FRAME, n, ok);
    chk("first_fs_latency", 32'(n), 32'(2));
    wait_fs(4 * FRAME, n, ok);
    de_cnt = vif0.hdmi_de ? 1 : 0;
    fell = 1'b0;
    for (int i = 1; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (i == FRAME / 2) enable = 1'b0;
      if (vif0.hdmi_de) de_cnt++;
      if (!vif0.running) begin
        fell = 1'b1;
        break;
      end
    end
    if (!fell) timeout("running_fall");
    chk("frame2_de_count", 32'(de_cnt), 32'(HA * VA));
    repeat (10) @(negedge clk);

    // random enable, including low-then-high pulses inside a frame
    repeat (800) begin
      @(negedge clk);
      enable = ($urandom_range(0, 3) != 0);
    end

    // asynchronous reset mid-frame at two positions
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      enable = 1'b1;
      wait_pos(rst_pos[k], 4 * FRAME);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_de",  32'(vif0.hdmi_de), 32'(0));
      chk("mid_rst_d",   32'(vif0.hdmi_d), 32'(0));
      chk("mid_rst_hs0", 32'(vif0.hdmi_hs), 32'(1));
      chk("mid_rst_vs0", 32'(vif0.hdmi_vs), 32'(1));
      chk("mid_rst_hs1", 32'(vif1.hdmi_hs), 32'(0));
      chk("mid_rst_vs1", 32'(vif1.hdmi_vs), 32'(0));
      chk("mid_rst_run", 32'(vif0.running), 32'(0));
      chk("mid_rst_req", 32'(vif0.pix_req), 32'(0));
      repeat (2) @(negedge clk);
      reset = 1'b0;
      wait_fs(4 * FRAME, n, ok);
      chk("post_rst_fs_latency", 32'(n), 32'(2));
      chk("post_rst_fs_de", 32'(vif0.hdmi_de), 32'(1));
    end

    enable = 1'b0;
    n = 0;
    while (m_run && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (m_run) timeout("final_idle");
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
